// File: rtl/btn_msg_streamer.sv
// Button-triggered message source: sync + debounce a push-button, then stream MSG_LEN words
// over a valid/ready byte interface. Define MSG_CRLF_EN to append a CR, LF terminator.
module btn_msg_streamer #(
    parameter int DATA_W          = 8,
    parameter int MSG_LEN         = 4,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        btn_i,
    input  logic [MSG_LEN*DATA_W-1:0]   msg_i,
    output logic [DATA_W-1:0]           t_data_o,
    output logic                        t_valid_o,
    input  logic                        t_ready_i,
    output logic                        busy_o,
    output logic                        done_o
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int IDX_W = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_LEN - 1);
`ifdef MSG_CRLF_EN
    localparam logic [DATA_W-1:0] CR_WORD = DATA_W'(8'h0D);
    localparam logic [DATA_W-1:0] LF_WORD = DATA_W'(8'h0A);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
`ifdef MSG_CRLF_EN
        S_CR,
        S_LF,
`endif
        S_LAST
    } state_t;

    // Valid/ready: a word transfers on any cycle with t_valid_o && t_ready_i; while valid
    // and not ready, data is held and valid stays high. Valid is a flop, never fed by ready.

    logic                      sync1_q, sync1_d, sync2_q, sync2_d;
    logic                      deb_level_q, deb_level_d;
    logic [CNT_W-1:0]          deb_cnt_q, deb_cnt_d;
    logic                      press_q, press_d;
    state_t                    state_q, state_d;
    logic [MSG_LEN*DATA_W-1:0] shreg_q, shreg_d, shifted;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [DATA_W-1:0]         t_data_q, t_data_d;
    logic                      t_valid_q, t_valid_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      hs;

    always_comb begin
        sync1_d     = btn_i;
        sync2_d     = sync1_q;
        deb_level_d = deb_level_q;
        deb_cnt_d   = '0;
        press_d     = 1'b0;
        if (sync2_q != deb_level_q) begin
            if (deb_cnt_q == CNT_MAX) begin
                deb_level_d = ~deb_level_q;
                press_d     = ~deb_level_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        idx_d     = idx_q;
        t_data_d  = t_data_q;
        t_valid_d = t_valid_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        hs        = t_valid_q & t_ready_i;
        shifted   = shreg_q >> DATA_W;
        case (state_q)
            S_IDLE: begin
                // Presses arriving while busy never reach here, so they are dropped.
                if (press_q) begin
                    shreg_d   = msg_i;
                    idx_d     = '0;
                    t_data_d  = msg_i[DATA_W-1:0];
                    t_valid_d = 1'b1;
                    busy_d    = 1'b1;
                    state_d   = (MSG_LEN == 1) ? S_LAST : S_SEND;
                end
            end
            S_SEND: begin
                if (hs) begin
                    shreg_d  = shifted;
                    idx_d    = idx_q + 1'b1;
                    t_data_d = shifted[DATA_W-1:0];
                    if (idx_q + 1'b1 == LAST_IDX) state_d = S_LAST;
                end
            end
`ifdef MSG_CRLF_EN
            S_LAST: begin
                if (hs) begin
                    t_data_d = CR_WORD;
                    state_d  = S_CR;
                end
            end
            S_CR: begin
                if (hs) begin
                    t_data_d = LF_WORD;
                    state_d  = S_LF;
                end
            end
            S_LF: begin
                if (hs) begin
                    t_data_d  = '0;
                    t_valid_d = 1'b0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    state_d   = S_IDLE;
                end
            end
`else
            S_LAST: begin
                if (hs) begin
                    t_data_d  = '0;
                    t_valid_d = 1'b0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    state_d   = S_IDLE;
                end
            end
`endif
            default: begin
                t_valid_d = 1'b0;
                busy_d    = 1'b0;
                state_d   = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            deb_level_q <= 1'b0;
            deb_cnt_q   <= '0;
            press_q     <= 1'b0;
            state_q     <= S_IDLE;
            shreg_q     <= '0;
            idx_q       <= '0;
            t_data_q    <= '0;
            t_valid_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            deb_level_q <= deb_level_d;
            deb_cnt_q   <= deb_cnt_d;
            press_q     <= press_d;
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            idx_q       <= idx_d;
            t_data_q    <= t_data_d;
            t_valid_q   <= t_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign t_data_o  = t_data_q;
    assign t_valid_o = t_valid_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;

endmodule

// File: tb/tb_btn_msg_streamer.sv
// Bench for btn_msg_streamer: directed steps plus random messages and ready patterns,
// checked by a byte scoreboard fed from the message words.
module tb_btn_msg_streamer;
  localparam int DATA_W  = 8;
  localparam int MSG_LEN = 4;
  localparam int DEB     = 16;
`ifdef MSG_CRLF_EN
  localparam int N_WORDS = MSG_LEN + 2;
`else
  localparam int N_WORDS = MSG_LEN;
`endif

  logic                      clk;
  logic                      rst_n;
  logic                      btn_i;
  logic [MSG_LEN*DATA_W-1:0] msg_i;
  logic [DATA_W-1:0]         t_data_o;
  logic                      t_valid_o;
  logic                      t_ready_i;
  logic                      busy_o;
  logic                      done_o;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int hs_cnt = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int hs_cyc[$];
  logic [DATA_W-1:0] exp_q[$];
  logic seen_valid = 1'b0;
  logic stall_prev = 1'b0;
  logic [DATA_W-1:0] stall_data = '0;
  logic [DATA_W-1:0] exp_w;
  logic rdy_rand = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  btn_msg_streamer #(
    .DATA_W(DATA_W),
    .MSG_LEN(MSG_LEN),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_i(btn_i),
    .msg_i(msg_i),
    .t_data_o(t_data_o),
    .t_valid_o(t_valid_o),
    .t_ready_i(t_ready_i),
    .busy_o(busy_o),
    .done_o(done_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor/scoreboard on the falling edge, away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (t_valid_o === 1'b1) seen_valid = 1'b1;
      check("valid_implies_busy", (!t_valid_o || busy_o), 1'b1);
      if (stall_prev) begin
        check("stall_valid_held", t_valid_o, 1'b1);
        check("stall_data_held", t_data_o, stall_data);
      end
      if (t_valid_o === 1'b1 && t_ready_i === 1'b1) begin
        hs_cnt++;
        hs_cyc.push_back(cyc);
        check("hs_word_expected", (exp_q.size() > 0), 1'b1);
        if (exp_q.size() > 0) begin
          exp_w = exp_q.pop_front();
          check("hs_word", t_data_o, exp_w);
        end
      end
      if (done_o === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
        check("done_valid_low", t_valid_o, 1'b0);
        check("done_busy_low", busy_o, 1'b0);
        check("done_all_words_sent", exp_q.size(), 0);
      end
      stall_prev = (t_valid_o === 1'b1 && t_ready_i !== 1'b1);
      stall_data = t_data_o;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rdy_rand) t_ready_i = ($urandom_range(0, 3) != 0);
  endtask

  task automatic push_msg(input logic [MSG_LEN*DATA_W-1:0] m);
    for (int i = 0; i < MSG_LEN; i++) exp_q.push_back(m[i*DATA_W +: DATA_W]);
`ifdef MSG_CRLF_EN
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
`endif
  endtask

  task automatic wait_valid(input string tag);
    int k;
    k = 0;
    while (t_valid_o !== 1'b1 && k < 80) begin
      tick();
      k++;
    end
    check(tag, t_valid_o, 1'b1);
  endtask

  task automatic wait_done(input int d0, input string tag);
    int k;
    k = 0;
    while (done_cnt == d0 && k < 400) begin
      tick();
      k++;
    end
    check(tag, (done_cnt > d0), 1'b1);
  endtask

  // Short glitches (below the debounce window) precede a clean 40-cycle press.
  task automatic press_msg(input logic [MSG_LEN*DATA_W-1:0] m, input int glitches);
    int d0;
    msg_i = m;
    push_msg(m);
    d0 = done_cnt;
    for (int g = 0; g < glitches; g++) begin
      btn_i = 1'b1;
      repeat ($urandom_range(1, 8)) tick();
      btn_i = 1'b0;
      repeat ($urandom_range(1, 8)) tick();
    end
    btn_i = 1'b1;
    repeat (40) tick();
    btn_i = 1'b0;
    wait_done(d0, "press_done_timeout");
    repeat (30) tick();
    check("press_one_done", done_cnt, d0 + 1);
    check("press_queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    int d0;
    int h0;
    rst_n     = 1'b0;
    btn_i     = 1'b0;
    msg_i     = '0;
    t_ready_i = 1'b0;

    // Step 1: reset and idle
    #12;
    check("rst_valid", t_valid_o, 1'b0);
    check("rst_data", t_data_o, 8'h00);
    check("rst_busy", busy_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_valid", t_valid_o, 1'b0);
      check("idle_busy", busy_o, 1'b0);
      check("idle_done", done_o, 1'b0);
      check("idle_data", t_data_o, 8'h00);
    end

    // Step 2: bouncing button with 5-cycle pulses never triggers
    seen_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      btn_i = 1'b1;
      repeat (5) tick();
      btn_i = 1'b0;
      repeat (5) tick();
    end
    check("bounce_no_valid", seen_valid, 1'b0);
    check("bounce_no_busy", busy_o, 1'b0);

    // Step 3: clean hold sends one message back-to-back with ready high
    rdy_rand  = 1'b0;
    t_ready_i = 1'b1;
    hs_cyc.delete();
    press_msg(32'h6C6C6548, 0);
    check("b2b_hs_count", hs_cyc.size(), N_WORDS);
    for (int i = 1; i < hs_cyc.size(); i++) check("b2b_consecutive", hs_cyc[i], hs_cyc[0] + i);
    if (hs_cyc.size() > 0) check("b2b_done_next_cycle", done_cyc, hs_cyc[hs_cyc.size()-1] + 1);

    // Step 4: stall during word 1
    t_ready_i = 1'b0;
    msg_i = 32'h6C6C6548;
    push_msg(msg_i);
    d0 = done_cnt;
    h0 = hs_cnt;
    btn_i = 1'b1;
    wait_valid("stall_start_timeout");
    check("stall_word0", t_data_o, 8'h48);
    t_ready_i = 1'b1;
    tick();
    t_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_hold_valid", t_valid_o, 1'b1);
      check("stall_hold_data", t_data_o, 8'h65);
    end
    t_ready_i = 1'b1;
    wait_done(d0, "stall_done_timeout");
    btn_i = 1'b0;
    repeat (30) tick();
    check("stall_hs_total", hs_cnt - h0, N_WORDS);
    check("stall_one_done", done_cnt, d0 + 1);
    check("stall_queue_drained", exp_q.size(), 0);

    // Step 5: press and msg_i change mid-message are ignored
    t_ready_i = 1'b0;
    msg_i = 32'h6C6C6548;
    push_msg(msg_i);
    d0 = done_cnt;
    btn_i = 1'b1;
    wait_valid("mid_start_timeout");
    t_ready_i = 1'b1;
    tick();
    t_ready_i = 1'b0;
    msg_i = 32'hFFFFFFFF;
    btn_i = 1'b0;
    repeat (22) tick();
    btn_i = 1'b1;
    repeat (24) tick();
    check("mid_still_busy", busy_o, 1'b1);
    t_ready_i = 1'b1;
    wait_done(d0, "mid_done_timeout");
    btn_i = 1'b0;
    repeat (40) tick();
    check("mid_one_done", done_cnt, d0 + 1);
    check("mid_queue_drained", exp_q.size(), 0);
    check("mid_idle_after", busy_o, 1'b0);
    rdy_rand = 1'b1;
    press_msg(32'hFFFFFFFF, 0);

    // Step 6: reset during word 2
    rdy_rand  = 1'b0;
    t_ready_i = 1'b0;
    msg_i = $urandom();
    push_msg(msg_i);
    btn_i = 1'b1;
    wait_valid("rst_mid_start_timeout");
    t_ready_i = 1'b1;
    tick();
    tick();
    t_ready_i = 1'b0;
    #2;
    rst_n = 1'b0;
    btn_i = 1'b0;
    #1;
    check("rst_mid_valid_drop", t_valid_o, 1'b0);
    check("rst_mid_busy_drop", busy_o, 1'b0);
    exp_q.delete();
    repeat (3) tick();
    rst_n = 1'b1;
    seen_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      check("post_rst_quiet", t_valid_o, 1'b0);
    end
    check("post_rst_no_busy", busy_o, 1'b0);

    // Random messages with random ready and glitchy presses
    rdy_rand = 1'b1;
    for (int r = 0; r < 6; r++) press_msg($urandom(), $urandom_range(0, 3));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/btn_msg_streamer.md
Name: btn_msg_streamer

Overview:
Parametrised button-triggered message source for the UART ALU board tops. It synchronises and debounces a raw push-button, then streams a multi-byte message over a valid/ready byte interface into the UART transmit path. It replaces the single hard-wired byte driven straight from a button in current board wrappers. It sits between board pins and the UART TX input of the core.

Parameters:
DATA_W, 8, bits per message word
MSG_LEN, 4, words per message (>=1)
DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a button level change (10 ms at 50 MHz; benches override to 16)

Ports:
clk  input  1  system clock, single domain
rst_n  input  1  asynchronous active-low reset
btn_i  input  1  raw button, active-high, asynchronous to clk, may bounce
msg_i  input  MSG_LEN*DATA_W  message; word 0 in bits [DATA_W-1:0], sent first
t_data_o  output  DATA_W  current word
t_valid_o  output  1  t_data_o valid
t_ready_i  input  1  downstream accepts word when t_valid_o && t_ready_i
busy_o  output  1  message in flight
done_o  output  1  one-cycle pulse after last word accepted

Behaviour:
- Reset (async assert, sync release): sync FFs=0, debounced level=0, debounce counter=0, FSM=IDLE, t_data_o=0, t_valid_o=0, busy_o=0, done_o=0. A reset mid-message drops t_valid_o immediately; nothing resumes after release.
- Sync: btn_i passes through 2 flops to give btn_s.
- Debounce: counter clears whenever btn_s equals the debounced level. Otherwise it increments. When it reaches DEBOUNCE_CYCLES-1 while still differing, the debounced level flips and the counter clears. Counter width is $clog2(DEBOUNCE_CYCLES).
- Press event: a one-cycle pulse on the debounced 0->1 transition. Release events are ignored.
- FSM states: IDLE, SEND, LAST (plus CR, LF with the optional feature).
- IDLE, press event: msg_i is snapshotted into a shift register, word index=0. Next state is SEND, or LAST if MSG_LEN==1.
- Latency: press-event cycle N gives t_valid_o=1 and busy_o=1 at N+1.
- SEND: t_valid_o=1 and t_data_o=current word. On handshake, shift by DATA_W and index++. When the index reaches MSG_LEN-1, go to LAST.
- LAST: on handshake of the final word, go to IDLE. done_o=1 for exactly the next cycle, and t_valid_o/busy_o drop that same cycle.
- Handshake rules:
  - t_data_o stays stable and t_valid_o never deasserts while t_valid_o && !t_ready_i.
  - One word per handshake cycle, so back-to-back words follow when t_ready_i is held high.
  - t_valid_o never depends combinationally on t_ready_i.
- Press events while busy_o=1 are ignored, not queued.
- Changes to msg_i after the snapshot do not affect the message in flight.
- A press event can be accepted in the cycle after done_o.
- Button held through reset release: debounced level starts at 0, so one press event fires after DEBOUNCE_CYCLES.

Optional Feature:
MSG_CRLF_EN: when defined, LAST's final handshake moves to CR (t_data_o=0x0D), then LF (t_data_o=0x0A), each with the same handshake rules. busy_o stays high through LF, and done_o pulses after the LF handshake. Message length on the wire is MSG_LEN+2. When undefined, no terminator is sent and there are exactly MSG_LEN words. Requires DATA_W>=8; the terminator bytes are zero-extended.

Test Plan:
1. Reset with btn_i=0, then 20 idle cycles -> all outputs 0, busy_o=0.
2. DEBOUNCE_CYCLES=16. btn_i toggles with 5-cycle high pulses for 100 cycles -> t_valid_o never asserts. Then btn_i held high 40 cycles -> exactly one message starts.
3. msg_i=32'h6C6C6548, t_ready_i=1, one press -> t_data_o 0x48,0x65,0x6C,0x6C on 4 consecutive cycles. done_o pulses once the cycle after 0x6C(2), then idle. With MSG_CRLF_EN, 0x0D,0x0A follow before done_o.
4. Same message, t_ready_i low for 5 cycles during word 1 -> t_data_o holds 0x65 with t_valid_o=1. Exactly 4 handshakes total, no loss or duplicate.
5. Second press mid-message and msg_i changed to 32'hFFFFFFFF mid-message -> original bytes sent, only one done_o. A press after done_o starts a new message of 0xFF bytes.
6. rst_n pulsed low during word 2 -> t_valid_o=0 in the same cycle, busy_o=0. After release, no output until a new debounced press.
